// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// =============================================================================
// shared_reg_arbiter : round-robin write arbiter for one shared WIDTH-bit reg
// Rev 1.0 -- optional grant timeout enabled by defining SHREG_TIMEOUT_EN
// =============================================================================
module shared_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*WIDTH-1:0]   wdata,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid
);

   localparam int c_OW = $clog2(N_REQ);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
   logic [c_OW-1:0]  r_owner, w_owner_nxt;
   logic [c_OW-1:0]  r_ptr, w_ptr_nxt;
   logic [c_OW-1:0]  w_sel;
   logic             w_any;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic             r_qv, w_qv_nxt;
   logic [WIDTH-1:0] w_owner_data;
   logic             w_owner_req;
`ifdef SHREG_TIMEOUT_EN
   localparam logic [7:0] c_MAX_HOLD = 8'(MAX_HOLD);
   logic [7:0]       r_cnt, w_cnt_nxt;
`endif

   if ((N_REQ < 2) || (N_REQ > 8) || (MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_params
      $error("shared_reg_arbiter: parameter out of range");
   end

   // Scan downward so the last hit is the nearest requester after the pointer.
   always_comb begin
      w_sel = r_ptr;
      w_any = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[c_OW'((int'(r_ptr) + k) % N_REQ)]) begin
            w_sel = c_OW'((int'(r_ptr) + k) % N_REQ);
            w_any = 1'b1;
         end
      end
   end

   assign w_owner_data = wdata[int'(r_owner)*WIDTH +: WIDTH];
   assign w_owner_req  = req[r_owner];

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_q_nxt     = r_q;
      w_qv_nxt    = r_qv;
`ifdef SHREG_TIMEOUT_EN
      w_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         ST_IDLE: begin
            w_gnt_nxt = '0;
            if (w_any) begin
               w_state_nxt      = ST_OWN;
               w_gnt_nxt[w_sel] = 1'b1;
               w_owner_nxt      = w_sel;
               w_ptr_nxt        = w_sel;
            end
         end
         ST_OWN: begin
            if (w_owner_req) begin
               w_q_nxt  = w_owner_data;
               w_qv_nxt = 1'b1;
`ifdef SHREG_TIMEOUT_EN
               if (r_cnt + 8'd1 == c_MAX_HOLD) begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = '0;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt   = r_cnt + 8'd1;
               end
`endif
            end else begin
               w_state_nxt = ST_IDLE;
               w_gnt_nxt   = '0;
`ifdef SHREG_TIMEOUT_EN
               w_cnt_nxt   = '0;
`endif
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gnt   <= '0;
         r_owner <= '0;
         r_ptr   <= c_OW'(N_REQ - 1);
         r_q     <= '0;
         r_qv    <= 1'b0;
`ifdef SHREG_TIMEOUT_EN
         r_cnt   <= '0;
`endif
      end else begin
         r_gnt   <= w_gnt_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_q     <= w_q_nxt;
         r_qv    <= w_qv_nxt;
`ifdef SHREG_TIMEOUT_EN
         r_cnt   <= w_cnt_nxt;
`endif
      end
   end

   assign gnt     = r_gnt;
   assign owner   = r_owner;
   assign q       = r_q;
   assign q_valid = r_qv;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arbiter.sv
`default_nettype none
// =============================================================================
// tb_shared_reg_arbiter : directed vector bench for shared_reg_arbiter
// Rev 1.0 -- expectations follow SHREG_TIMEOUT_EN when it is defined
// =============================================================================
module tb_shared_reg_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic [7:0]  q;
   logic        q_valid;

   int total = 0;
   int bad   = 0;

   shared_reg_arbiter #(
      .N_REQ    (4),
      .WIDTH    (8),
      .MAX_HOLD (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .wdata   (wdata),
      .gnt     (gnt),
      .owner   (owner),
      .q       (q),
      .q_valid (q_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] wdata;
      logic [3:0]  gnt;
      logic [1:0]  owner;
      logic [7:0]  q;
      logic        qv;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] rq, input logic [31:0] wd,
                               input logic [3:0] g, input logic [1:0] o, input logic [7:0] qq,
                               input logic v);
      vecs.push_back('{r, rq, wd, g, o, qq, v});
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                            input logic [7:0] eq, input logic ev);
      check({tag, " gnt"},     32'(gnt),     32'(eg));
      check({tag, " owner"},   32'(owner),   32'(eo));
      check({tag, " q"},       32'(q),       32'(eq));
      check({tag, " q_valid"}, 32'(q_valid), 32'(ev));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] eg;
      logic [1:0] eo;
      logic [7:0] eq;

      rst   = 1'b0;
      req   = '0;
      wdata = '0;

      // single requester 2
      add(1'b0, 4'b0000, 32'hDEADBEEF, 4'b0000, 2'd0, 8'h00, 1'b0);
      add(1'b1, 4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'h00, 1'b0);
      add(1'b1, 4'b0100, 32'h00A50000, 4'b0100, 2'd2, 8'hA5, 1'b1);
      add(1'b1, 4'b0100, 32'h003C0000, 4'b0100, 2'd2, 8'h3C, 1'b1);
      add(1'b1, 4'b0100, 32'h007E0000, 4'b0100, 2'd2, 8'h7E, 1'b1);
      add(1'b1, 4'b0000, 32'h00110000, 4'b0000, 2'd2, 8'h7E, 1'b1);
      add(1'b1, 4'b0000, 32'h00000000, 4'b0000, 2'd2, 8'h7E, 1'b1);
      // round robin from reset: 0,1,2,3,0
      add(1'b0, 4'b1111, 32'h12345678, 4'b0000, 2'd0, 8'h00, 1'b0);
      add(1'b1, 4'b1111, 32'h00000000, 4'b0001, 2'd0, 8'h00, 1'b0);
      add(1'b1, 4'b1111, 32'h00000010, 4'b0001, 2'd0, 8'h10, 1'b1);
      add(1'b1, 4'b1111, 32'h00000011, 4'b0001, 2'd0, 8'h11, 1'b1);
      add(1'b1, 4'b1110, 32'h00000099, 4'b0000, 2'd0, 8'h11, 1'b1);
      add(1'b1, 4'b1111, 32'h00000000, 4'b0010, 2'd1, 8'h11, 1'b1);
      add(1'b1, 4'b1111, 32'h00002100, 4'b0010, 2'd1, 8'h21, 1'b1);
      add(1'b1, 4'b1111, 32'h00002200, 4'b0010, 2'd1, 8'h22, 1'b1);
      add(1'b1, 4'b1101, 32'h00000000, 4'b0000, 2'd1, 8'h22, 1'b1);
      add(1'b1, 4'b1111, 32'h00000000, 4'b0100, 2'd2, 8'h22, 1'b1);
      add(1'b1, 4'b1111, 32'h00310000, 4'b0100, 2'd2, 8'h31, 1'b1);
      add(1'b1, 4'b1111, 32'h00320000, 4'b0100, 2'd2, 8'h32, 1'b1);
      add(1'b1, 4'b1011, 32'h00000000, 4'b0000, 2'd2, 8'h32, 1'b1);
      add(1'b1, 4'b1111, 32'h00000000, 4'b1000, 2'd3, 8'h32, 1'b1);
      add(1'b1, 4'b1111, 32'h41000000, 4'b1000, 2'd3, 8'h41, 1'b1);
      add(1'b1, 4'b1111, 32'h42000000, 4'b1000, 2'd3, 8'h42, 1'b1);
      add(1'b1, 4'b0111, 32'h00000000, 4'b0000, 2'd3, 8'h42, 1'b1);
      add(1'b1, 4'b1111, 32'h00000000, 4'b0001, 2'd0, 8'h42, 1'b1);
      // fairness: owner 1 releases with 0 and 3 waiting, 3 wins
      add(1'b1, 4'b1010, 32'h00000000, 4'b0000, 2'd0, 8'h42, 1'b1);
      add(1'b1, 4'b1010, 32'h00000000, 4'b0010, 2'd1, 8'h42, 1'b1);
      add(1'b1, 4'b1011, 32'h00005500, 4'b0010, 2'd1, 8'h55, 1'b1);
      add(1'b1, 4'b1001, 32'h00000000, 4'b0000, 2'd1, 8'h55, 1'b1);
      add(1'b1, 4'b1001, 32'h00000000, 4'b1000, 2'd3, 8'h55, 1'b1);
      add(1'b1, 4'b0000, 32'h00000000, 4'b0000, 2'd3, 8'h55, 1'b1);
      // first grant dropped immediately: no write, q_valid stays low
      add(1'b0, 4'b1111, 32'hFFFFFFFF, 4'b0000, 2'd0, 8'h00, 1'b0);
      add(1'b1, 4'b0010, 32'h00007700, 4'b0010, 2'd1, 8'h00, 1'b0);
      add(1'b1, 4'b0000, 32'h00007700, 4'b0000, 2'd1, 8'h00, 1'b0);
      add(1'b1, 4'b0000, 32'h00000000, 4'b0000, 2'd1, 8'h00, 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst   = vecs[i].rst;
         req   = vecs[i].req;
         wdata = vecs[i].wdata;
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].gnt, vecs[i].owner, vecs[i].q, vecs[i].qv);
      end

      // long hold by requester 0 while requester 1 waits
      @(negedge clk);
      req   = 4'b0011;
      wdata = 32'h00000090;
      @(posedge clk);
      #1;
      check_all("hold grant", 4'b0001, 2'd0, 8'h00, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         wdata = {16'h0000, 8'(8'hB0 + k), 8'(8'h90 + k)};
         @(posedge clk);
         #1;
`ifdef SHREG_TIMEOUT_EN
         if (k < 4) begin
            eg = 4'b0001; eo = 2'd0; eq = 8'(8'h90 + k);
         end else if (k == 4) begin
            eg = 4'b0000; eo = 2'd0; eq = 8'h94;
         end else if (k == 5) begin
            eg = 4'b0010; eo = 2'd1; eq = 8'h94;
         end else begin
            eg = 4'b0010; eo = 2'd1; eq = 8'hB6;
         end
`else
         eg = 4'b0001; eo = 2'd0; eq = 8'(8'h90 + k);
`endif
         check_all($sformatf("hold k%0d", k), eg, eo, eq, 1'b1);
      end

      // asynchronous reset in the middle of an owned cycle
      @(negedge clk);
      wdata = 32'h55555555;
      #2;
      rst = 1'b0;
      #1;
      check_all("async rst", 4'b0000, 2'd0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check_all("rst held edge", 4'b0000, 2'd0, 8'h00, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0000;
      @(posedge clk);
      #1;
      check_all("post rst idle", 4'b0000, 2'd0, 8'h00, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
